// File: rtl/ft245_device_responder_pkg.sv
// Shared constants and FSM encodings for the FT245 device-side responder.
package ft245_device_responder_pkg;

  localparam int SYNC_STAGES = 2;
  localparam int BUS_W       = 8;
  localparam int CNT_W       = 3;

  typedef logic [BUS_W-1:0] byte_t;

  // Read FSM encodings
  localparam logic [1:0] RD_IDLE  = 2'd0;
  localparam logic [1:0] RD_WAIT  = 2'd1;
  localparam logic [1:0] RD_DRIVE = 2'd2;
  localparam logic [1:0] RD_RECOV = 2'd3;

  // Write FSM encodings
  localparam logic [1:0] WR_IDLE  = 2'd0;
  localparam logic [1:0] WR_LOW   = 2'd1;
  localparam logic [1:0] WR_RECOV = 2'd2;

endpackage

// File: rtl/ft245_device_responder_if.sv
// Strobe/flag side of the FT245 bus plus the host valid/ready byte streams.
// The data bus itself stays a plain inout on the top module.
interface ft245_device_responder_if;
  import ft245_device_responder_pkg::*;

  logic  ftdi_rd_n;
  logic  ftdi_wr_n;
  logic  ftdi_rxf_n;
  logic  ftdi_txe_n;
  logic  ftdi_oe;         // high while the responder drives the data bus

  byte_t host_in_data;
  logic  host_in_valid;
  logic  host_in_ready;

  byte_t host_out_data;
  logic  host_out_valid;
  logic  host_out_ready;

  logic  err;

  modport slave (
    input  ftdi_rd_n, ftdi_wr_n,
    output ftdi_rxf_n, ftdi_txe_n, ftdi_oe,
    input  host_in_data, host_in_valid,
    output host_in_ready,
    output host_out_data, host_out_valid,
    input  host_out_ready,
    output err
  );

  modport master (
    output ftdi_rd_n, ftdi_wr_n,
    input  ftdi_rxf_n, ftdi_txe_n, ftdi_oe,
    output host_in_data, host_in_valid,
    input  host_in_ready,
    input  host_out_data, host_out_valid,
    output host_out_ready,
    input  err
  );

endinterface

// File: rtl/ft245_device_responder_byte_fifo.sv
// Synchronous byte FIFO. A pop in the same cycle as a push on a full FIFO
// frees the slot first, so the push is accepted.
module ft245_device_responder_byte_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign full     = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);

  // Next pointer and occupancy values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ft245_device_responder.sv
// Device-side FT245 async FIFO responder: synchronises controller strobes,
// answers reads from the RX FIFO and captures writes into the TX FIFO.
//
// state    | meaning
// RD_IDLE  | rxf_n reflects RX empty, waiting for rd_n fall
// RD_WAIT  | read latency countdown, bus still released
// RD_DRIVE | RX head on the bus, waiting for rd_n rise
// RD_RECOV | rxf_n held inactive for RECOVERY cycles
// WR_IDLE  | txe_n reflects TX space, waiting for wr_n fall
// WR_LOW   | byte captured, waiting for wr_n rise
// WR_RECOV | txe_n held inactive for RECOVERY cycles
module ft245_device_responder
  import ft245_device_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int RD_LAT     = 2,   // 1..7
  parameter int RECOVERY   = 2    // 1..7
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  inout  wire  [BUS_W-1:0]        io_ftdi_data,
  ft245_device_responder_if.slave bus
);

  logic [SYNC_STAGES-1:0]            rd_sync_q, rd_sync_d;
  logic [SYNC_STAGES-1:0]            wr_sync_q, wr_sync_d;
  logic [SYNC_STAGES-1:0][BUS_W-1:0] data_sync_q, data_sync_d;
  logic                              rd_prev_q, rd_prev_d;
  logic                              wr_prev_q, wr_prev_d;
  logic                              ready_q, ready_d;
  logic                              err_q, err_d;
  logic [1:0]                        rd_state_q, rd_state_d;
  logic [1:0]                        wr_state_q, wr_state_d;
  logic [CNT_W-1:0]                  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]                  wr_cnt_q, wr_cnt_d;

  logic        rd_s, wr_s, rd_fall, rd_rise, wr_fall, wr_rise, both_low;
  logic        rx_avail, tx_space, rd_ok, wr_ok, violation;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic        tx_push, tx_pop, tx_full, tx_empty;
  byte_t       rx_head;
  logic [DEPTH_LOG2:0] rx_count, tx_count;
  logic        unused_counts;

  assign unused_counts = ^{rx_count, tx_count};

  ft245_device_responder_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(BUS_W)) u_rx_fifo (
    .clk       (in_clk),
    .rst       (in_rst),
    .push      (rx_push),
    .push_data (bus.host_in_data),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  ft245_device_responder_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(BUS_W)) u_tx_fifo (
    .clk       (in_clk),
    .rst       (in_rst),
    .push      (tx_push),
    .push_data (data_sync_q[SYNC_STAGES-1]),
    .pop       (tx_pop),
    .pop_data  (bus.host_out_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  // Synchroniser shifts and edge-detect history
  always_comb begin
    rd_sync_d   = {rd_sync_q[SYNC_STAGES-2:0], bus.ftdi_rd_n};
    wr_sync_d   = {wr_sync_q[SYNC_STAGES-2:0], bus.ftdi_wr_n};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], io_ftdi_data};
    rd_prev_d   = rd_sync_q[SYNC_STAGES-1];
    wr_prev_d   = wr_sync_q[SYNC_STAGES-1];
    ready_d     = 1'b1;
  end

  assign rd_s     = rd_sync_q[SYNC_STAGES-1];
  assign wr_s     = wr_sync_q[SYNC_STAGES-1];
  assign rd_fall  = rd_prev_q & ~rd_s;
  assign rd_rise  = ~rd_prev_q & rd_s;
  assign wr_fall  = wr_prev_q & ~wr_s;
  assign wr_rise  = ~wr_prev_q & wr_s;
  assign both_low = ~rd_s & ~wr_s;

  // Host pop frees a TX slot in the same cycle, so it counts as space.
  assign tx_pop   = bus.host_out_ready & ~tx_empty;
  assign rx_avail = ready_q & (rd_state_q == RD_IDLE) & ~rx_empty;
  assign tx_space = ready_q & (wr_state_q == WR_IDLE) & (~tx_full | tx_pop);

  // A strobe that arrives against an inactive flag, or overlaps the other
  // strobe, is flagged and otherwise ignored.
  assign rd_ok     = rd_fall & rx_avail & ~both_low;
  assign wr_ok     = wr_fall & tx_space & ~both_low;
  assign violation = (rd_fall & ~rx_avail) | (wr_fall & ~tx_space) | both_low;

  assign rx_push = bus.host_in_valid & bus.host_in_ready;
  assign rx_pop  = (rd_state_q == RD_DRIVE) & rd_rise;
  assign tx_push = wr_ok;

  assign bus.ftdi_rxf_n     = ~rx_avail;
  assign bus.ftdi_txe_n     = ~tx_space;
  assign bus.ftdi_oe        = (rd_state_q == RD_DRIVE);
  assign bus.host_in_ready  = ready_q & ~rx_full;
  assign bus.host_out_valid = ~tx_empty;
  assign bus.err            = err_q;
  assign io_ftdi_data       = bus.ftdi_oe ? rx_head : 'z;

  // Read FSM: counters load on entry and leave the state when they hit zero
  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (rd_ok) begin
          rd_state_d = RD_WAIT;
          rd_cnt_d   = CNT_W'(RD_LAT);
        end
      end
      RD_WAIT: begin
        rd_cnt_d = rd_cnt_q - 1'b1;
        if (rd_cnt_d == '0) rd_state_d = RD_DRIVE;
      end
      RD_DRIVE: begin
        if (rd_rise) begin
          rd_state_d = RD_RECOV;
          rd_cnt_d   = CNT_W'(RECOVERY);
        end
      end
      RD_RECOV: begin
        rd_cnt_d = rd_cnt_q - 1'b1;
        if (rd_cnt_d == '0) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Write FSM: byte is captured on the accepted fall, rise starts recovery
  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (wr_ok) wr_state_d = WR_LOW;
      end
      WR_LOW: begin
        if (wr_rise) begin
          wr_state_d = WR_RECOV;
          wr_cnt_d   = CNT_W'(RECOVERY);
        end
      end
      WR_RECOV: begin
        wr_cnt_d = wr_cnt_q - 1'b1;
        if (wr_cnt_d == '0) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Sticky protocol error
  always_comb begin
    err_d = err_q | violation;
  end

  // All control state; reset releases the bus immediately via rd_state_q
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      rd_sync_q   <= '1;
      wr_sync_q   <= '1;
      data_sync_q <= '0;
      rd_prev_q   <= 1'b1;
      wr_prev_q   <= 1'b1;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      rd_state_q  <= RD_IDLE;
      wr_state_q  <= WR_IDLE;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
    end else begin
      rd_sync_q   <= rd_sync_d;
      wr_sync_q   <= wr_sync_d;
      data_sync_q <= data_sync_d;
      rd_prev_q   <= rd_prev_d;
      wr_prev_q   <= wr_prev_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      rd_state_q  <= rd_state_d;
      wr_state_q  <= wr_state_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

endmodule
